d5m_stream_gen: RTL and testbench

Synthesizable D5M sensor-output emulator: generates the pixel-clock-domain stream (12-bit data, FVAL, LVAL) that the camera capture path consumes. Timing and test patterns are programmable. It drops in place of the D5M_D/D5M_FVAL/D5M_LVAL pins, which lets the capture, gray/edge and frame-buffer path be exercised in simulation and on a board with no camera fitted.

---
 rtl/d5m_stream_gen_pkg.sv | 38 +++
 rtl/d5m_stream_gen_if.sv | 14 +
 rtl/d5m_stream_gen_pix.sv | 67 ++++++
 rtl/d5m_stream_gen.sv | 176 +++++++++++++++++
 tb/tb_d5m_stream_gen.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/d5m_stream_gen_pkg.sv
// d5m_stream_gen_pkg
//   Shared definitions for the D5M sensor-output emulator: FSM state
//   encoding, test-pattern codes, LFSR seed, colour-bar table and the
//   Bayer site helper used by the pattern datapath.
package d5m_stream_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FRONT,
    ST_LINE,
    ST_HBLANK,
    ST_BACK,
    ST_VBLANK
  } state_t;

  localparam logic [1:0] PAT_XRAMP = 2'd0;
  localparam logic [1:0] PAT_YRAMP = 2'd1;
  localparam logic [1:0] PAT_BARS  = 2'd2;
  localparam logic [1:0] PAT_LFSR  = 2'd3;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Each entry is {R,G,B}; index 0 is the leftmost bar.
  // white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [7:0][2:0] BAR_RGB = {
    3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
  };

  // Bayer 2x2 cell: G on the diagonal, R on even rows, B on odd rows.
  function automatic logic bayer_on(input logic [2:0] rgb,
                                    input logic       y_odd,
                                    input logic       x_odd);
    if (y_odd == x_odd) return rgb[1];
    else if (!y_odd)    return rgb[2];
    else                return rgb[0];
  endfunction

endpackage

// File: rtl/d5m_stream_gen_if.sv
// d5m_stream_gen_if
//   D5M sensor pin bundle as seen by the capture path.
//   d5m_d    : 12-bit pixel data (0 whenever d5m_lval is low)
//   d5m_fval : frame valid
//   d5m_lval : line valid
//   master : driven by the emulator; slave : consumed by the capture logic.
interface d5m_stream_gen_if;
  logic [11:0] d5m_d;
  logic        d5m_fval;
  logic        d5m_lval;

  modport master (output d5m_d, d5m_fval, d5m_lval);
  modport slave  (input  d5m_d, d5m_fval, d5m_lval);
endinterface

// File: rtl/d5m_stream_gen_pix.sv
// d5m_stream_gen_pix
//   Pattern datapath. Combinational pixel from the current X/Y/bar
//   position and the frame's latched pattern code; owns the LFSR.
//   Optional feature macro: D5M_STREAM_GEN_LFSR_EN (pattern 3 = LFSR;
//   without it pattern 3 is an X ramp and clk/rst_n/advance/reload
//   are not present).
//   Ports:
//     clk, rst_n : pixel clock, sync active-low reset (LFSR build only)
//     x, y       : position inside the active window
//     bar        : colour bar index 0..7
//     pattern    : latched pattern code
//     active     : high during LINE; pixel is 0 otherwise
//     advance    : step the LFSR after this cycle (LFSR build only)
//     reload     : load LFSR_SEED (LFSR build only)
//     pix        : 12-bit pixel value
module d5m_stream_gen_pix
  import d5m_stream_gen_pkg::*;
#(
  parameter int unsigned XW = 11,
  parameter int unsigned YW = 10
) (
`ifdef D5M_STREAM_GEN_LFSR_EN
  input  logic          clk,
  input  logic          rst_n,
  input  logic          advance,
  input  logic          reload,
`endif
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic [2:0]    bar,
  input  logic [1:0]    pattern,
  input  logic          active,
  output logic [11:0]   pix
);

  logic [11:0] x12;
  logic [11:0] y12;

  assign x12 = 12'(x);
  assign y12 = 12'(y);

`ifdef D5M_STREAM_GEN_LFSR_EN
  logic [15:0] lfsr;

  // Right-shifting Fibonacci form; bits 0,2,3,5 are taps 16,14,13,11.
  always_ff @(posedge clk) begin
    if (!rst_n)       lfsr <= LFSR_SEED;
    else if (reload)  lfsr <= LFSR_SEED;
    else if (advance) lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end
`endif

  always_comb begin
    pix = '0;
    if (active) begin
      case (pattern)
        PAT_YRAMP: pix = y12;
        PAT_BARS:  pix = {12{bayer_on(BAR_RGB[bar], y[0], x[0])}};
`ifdef D5M_STREAM_GEN_LFSR_EN
        PAT_LFSR:  pix = lfsr[11:0];
`endif
        default:   pix = x12;
      endcase
    end
  end

endmodule

// File: rtl/d5m_stream_gen.sv
// d5m_stream_gen
//   D5M sensor-output emulator: produces the pixel-clock-domain
//   D/FVAL/LVAL stream with programmable timing and test patterns.
//   Optional feature macro: D5M_STREAM_GEN_LFSR_EN (LFSR pattern 3).
//   Ports:
//     clk         : pixel clock, rising edge
//     rst_n       : synchronous active-low reset
//     start       : begin streaming when idle
//     stop        : finish at the next frame boundary (sticky)
//     pattern_sel : 0 X ramp, 1 Y ramp, 2 Bayer bars, 3 LFSR
//     d5m         : master side of the D5M pin bundle
//     busy        : high whenever not idle
//     frame_cnt   : completed frames (wraps)
module d5m_stream_gen
  import d5m_stream_gen_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned V_ACTIVE = 960,
  parameter int unsigned H_BLANK  = 384,
  parameter int unsigned F2L      = 8,
  parameter int unsigned L2F      = 8,
  parameter int unsigned V_BLANK  = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic [1:0]              pattern_sel,
  d5m_stream_gen_if.master        d5m,
  output logic                    busy,
  output logic [31:0]             frame_cnt
);

  localparam int unsigned M0    = (H_ACTIVE > H_BLANK) ? H_ACTIVE : H_BLANK;
  localparam int unsigned M1    = (F2L > L2F) ? F2L : L2F;
  localparam int unsigned M2    = (M0 > M1) ? M0 : M1;
  localparam int unsigned CMAX  = (M2 > V_BLANK) ? M2 : V_BLANK;
  localparam int unsigned CW    = $clog2(CMAX);
  localparam int unsigned XW    = $clog2(H_ACTIVE);
  localparam int unsigned YW    = $clog2(V_ACTIVE);
  localparam int unsigned BAR_W = H_ACTIVE / 8;
  localparam int unsigned BPW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [CW-1:0]  F2L_LAST = CW'(F2L - 1);
  localparam logic [CW-1:0]  H_LAST   = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0]  HB_LAST  = CW'(H_BLANK - 1);
  localparam logic [CW-1:0]  L2F_LAST = CW'(L2F - 1);
  localparam logic [CW-1:0]  VB_LAST  = CW'(V_BLANK - 1);
  localparam logic [YW-1:0]  Y_LAST   = YW'(V_ACTIVE - 1);
  localparam logic [BPW-1:0] BAR_LAST = BPW'(BAR_W - 1);

  state_t         state;
  logic [CW-1:0]  cnt;       // phase counter; doubles as X during LINE
  logic [YW-1:0]  y;
  logic [2:0]     bar;
  logic [BPW-1:0] bar_pos;
  logic [1:0]     pat;
  logic           stop_req;
  logic           in_line;
  logic [11:0]    pix;

  assign in_line = (state == ST_LINE);

  d5m_stream_gen_pix #(
    .XW (XW),
    .YW (YW)
  ) u_pix (
`ifdef D5M_STREAM_GEN_LFSR_EN
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (in_line),
    .reload  (state == ST_FRONT),
`endif
    .x       (cnt[XW-1:0]),
    .y       (y),
    .bar     (bar),
    .pattern (pat),
    .active  (in_line),
    .pix     (pix)
  );

  // Outputs are registered from the state held during the current cycle,
  // so d5m_d and d5m_lval come out of the same flop stage with no skew.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      y            <= '0;
      bar          <= '0;
      bar_pos      <= '0;
      pat          <= '0;
      stop_req     <= 1'b0;
      frame_cnt    <= '0;
      busy         <= 1'b0;
      d5m.d5m_d    <= '0;
      d5m.d5m_fval <= 1'b0;
      d5m.d5m_lval <= 1'b0;
    end else begin
      d5m.d5m_d    <= pix;
      d5m.d5m_fval <= state inside {ST_FRONT, ST_LINE, ST_HBLANK, ST_BACK};
      d5m.d5m_lval <= in_line;
      busy         <= (state != ST_IDLE);

      if (stop && state != ST_IDLE) stop_req <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_FRONT;
            cnt   <= '0;
            y     <= '0;
            pat   <= pattern_sel;
          end
        end
        ST_FRONT: begin
          if (cnt == F2L_LAST) begin
            state <= ST_LINE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_LINE: begin
          // bar and bar_pos wrap back to 0 exactly at the end of each line
          if (bar_pos == BAR_LAST) begin
            bar_pos <= '0;
            bar     <= bar + 1'b1;
          end else begin
            bar_pos <= bar_pos + 1'b1;
          end
          if (cnt == H_LAST) begin
            cnt   <= '0;
            state <= (y == Y_LAST) ? ST_BACK : ST_HBLANK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_HBLANK: begin
          if (cnt == HB_LAST) begin
            state <= ST_LINE;
            cnt   <= '0;
            y     <= y + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_BACK: begin
          if (cnt == L2F_LAST) begin
            state     <= ST_VBLANK;
            cnt       <= '0;
            frame_cnt <= frame_cnt + 32'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_VBLANK: begin
          if (cnt == VB_LAST) begin
            cnt <= '0;
            if (stop_req || stop) begin
              state    <= ST_IDLE;
              stop_req <= 1'b0;
            end else begin
              state <= ST_FRONT;
              y     <= '0;
              pat   <= pattern_sel;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_d5m_stream_gen.sv
// tb_d5m_stream_gen
//   Self-checking bench for d5m_stream_gen with a small timing set.
//   Expected streams come from a frame-position model: the output time
//   since fval rose is decomposed into front porch / line / blank /
//   back porch by arithmetic, and each pixel is derived from the
//   pattern rules. Honours D5M_STREAM_GEN_LFSR_EN for pattern 3.
module tb_d5m_stream_gen;

  localparam int H   = 8;
  localparam int V   = 4;
  localparam int HB  = 3;
  localparam int F2L = 2;
  localparam int L2F = 2;
  localparam int VB  = 5;
  localparam int ACT = V * H + (V - 1) * HB;
  localparam int FL  = F2L + ACT + L2F;
  localparam int P   = FL + VB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic        busy;
  logic [31:0] frame_cnt;

  int n_checks = 0;
  int n_fail = 0;
  int exp_frames = 0;

  // {R,G,B} per bar: white, yellow, cyan, green, magenta, red, blue, black
  int bar_rgb[8] = '{7, 6, 3, 2, 5, 4, 1, 0};

  d5m_stream_gen_if d5m_bus ();

  d5m_stream_gen #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .H_BLANK  (HB),
    .F2L      (F2L),
    .L2F      (L2F),
    .V_BLANK  (VB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .pattern_sel (pattern_sel),
    .d5m         (d5m_bus),
    .busy        (busy),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    int v;
    int fb;
    v  = int'(s);
    fb = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
    return 16'((v >> 1) | (fb << 15));
  endfunction

  function automatic logic [11:0] exp_pix(input int p, input int x, input int y,
                                          input logic [15:0] lf);
    int rgb;
    int mask;
    case (p)
      1: return 12'(y);
      2: begin
        rgb = bar_rgb[x / (H / 8)];
        if ((x % 2) == (y % 2)) mask = 2;
        else if ((y % 2) == 0)  mask = 4;
        else                    mask = 1;
        return ((rgb & mask) != 0) ? 12'hFFF : 12'h000;
      end
`ifdef D5M_STREAM_GEN_LFSR_EN
      3: return lf[11:0];
`endif
      default: return 12'(x);
    endcase
  endfunction

  // Position within a frame period, t = 0 on the first fval-high cycle.
  task automatic frame_pos(input int t, output bit fv, output bit lv,
                           output int x, output int y);
    int u;
    fv = (t < FL);
    lv = 1'b0;
    x  = 0;
    y  = 0;
    if (t >= F2L && t < F2L + ACT) begin
      u  = t - F2L;
      y  = u / (H + HB);
      x  = u % (H + HB);
      lv = (x < H);
    end
  endtask

  // Called on a negedge while idle; returns on the first fval-high negedge.
  task automatic launch(input logic [1:0] pat, input bit with_stop);
    pattern_sel = pat;
    start = 1'b1;
    stop  = with_stop;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check("latency_fval", 32'(d5m_bus.d5m_fval), 32'd0);
    check("latency_busy", 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  // Checks nframes whole periods; stop is pulsed mid-line of the last one.
  task automatic play(input int nframes, input logic [1:0] first_pat);
    int pat;
    int next_pat;
    int stop_t;
    logic [15:0] lf;
    bit fv, lv;
    int x, y;
    logic [11:0] ed;
    pat = int'(first_pat);
    for (int f = 0; f < nframes; f++) begin
      next_pat = $urandom_range(0, 3);
      stop_t   = F2L + $urandom_range(0, V - 1) * (H + HB) + $urandom_range(0, H - 1);
      lf = 16'hACE1;
      for (int t = 0; t < P; t++) begin
        frame_pos(t, fv, lv, x, y);
        ed = lv ? exp_pix(pat, x, y, lf) : 12'h000;
        check("stream", 32'({d5m_bus.d5m_fval, d5m_bus.d5m_lval, d5m_bus.d5m_d}),
              32'({fv, lv, ed}));
        check("busy_run", 32'(busy), 32'd1);
        if (t == 0) check("frame_cnt_start", frame_cnt, 32'(exp_frames));
        if (t == FL) begin
          exp_frames++;
          check("frame_cnt_done", frame_cnt, 32'(exp_frames));
        end
        if (lv) lf = lfsr_next(lf);
        // pattern_sel is noise during line 0 and holds the next frame's code elsewhere
        pattern_sel = (lv && y == 0) ? 2'($urandom) : 2'(next_pat);
        stop  = (f == nframes - 1) && (t == stop_t);
        start = (lv && y > 0) ? ($urandom_range(0, 7) == 0) : 1'b0;
        @(negedge clk);
      end
      pat = next_pat;
    end
    stop  = 1'b0;
    start = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_fval", 32'(d5m_bus.d5m_fval), 32'd0);
    check("idle_frame_cnt", frame_cnt, 32'(exp_frames));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] p;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_fval", 32'(d5m_bus.d5m_fval), 32'd0);
    check("rst_lval", 32'(d5m_bus.d5m_lval), 32'd0);
    check("rst_d", 32'(d5m_bus.d5m_d), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_cnt", frame_cnt, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single X-ramp frame: basic timing and ramp
    launch(2'd0, 1'b0);
    play(1, 2'd0);

    // Stop while idle must not be remembered
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_stop_fval", 32'(d5m_bus.d5m_fval), 32'd0);
    end

    // Multi-frame run with random patterns, stop in the last frame
    p = 2'($urandom);
    launch(p, 1'b0);
    play(3, p);

    // start and stop together while idle: start wins
    launch(2'd2, 1'b1);
    play(2, 2'd2);

    launch(2'd1, 1'b0);
    play(2, 2'd1);

`ifdef D5M_STREAM_GEN_LFSR_EN
    launch(2'd3, 1'b0);
    play(2, 2'd3);
`endif

    // Reset in the middle of line 0
    p = 2'($urandom);
    launch(p, 1'b0);
    repeat (F2L + 3) @(negedge clk);
    check("pre_rst_lval", 32'(d5m_bus.d5m_lval), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_fval", 32'(d5m_bus.d5m_fval), 32'd0);
    check("midrst_lval", 32'(d5m_bus.d5m_lval), 32'd0);
    check("midrst_d", 32'(d5m_bus.d5m_d), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_frame_cnt", frame_cnt, 32'd0);
    rst_n = 1'b1;
    exp_frames = 0;
    @(negedge clk);
    check("post_rst_fval", 32'(d5m_bus.d5m_fval), 32'd0);
    p = 2'($urandom);
    launch(p, 1'b0);
    play(1, p);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
